// File: rtl/riscv_bus_pkg.sv
// Shared types and address-decode helpers for the core bus bridge and its GPIO block.
// Pure declarations: no latency, no backpressure.
package riscv_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MEM_WAIT,
      ST_RESP
   } bus_state_t;

   typedef enum logic [1:0] {
      RGN_NONE,
      RGN_MEM,
      RGN_GPIO
   } region_t;

   // Word index of each register inside a channel's 16-byte window.
   localparam logic [1:0] GPIO_REG_OUT  = 2'd0;
   localparam logic [1:0] GPIO_REG_IN   = 2'd1;
   localparam logic [1:0] GPIO_REG_PEND = 2'd2;
   localparam logic [1:0] GPIO_REG_IEN  = 2'd3;

   localparam int GPIO_STRIDE = 16;

   // Wide arithmetic so base+size can never wrap for a 32-bit bus.
   function automatic region_t decode_region(
      input logic [63:0] addr,
      input logic [63:0] mem_base,
      input logic [63:0] mem_bytes,
      input logic [63:0] gpio_base,
      input logic [63:0] gpio_bytes
   );
      if (addr >= mem_base && addr < mem_base + mem_bytes)
         return RGN_MEM;
      else if (addr >= gpio_base && addr < gpio_base + gpio_bytes)
         return RGN_GPIO;
      else
         return RGN_NONE;
   endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// One GPIO channel: 2-flop synchroniser plus rising-edge detect; rise is valid 2 cycles after the pin.
// No handshake; pins are sampled every cycle.
module gpio_sync_edge #(
   parameter int GPIO_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [GPIO_WIDTH-1:0] pins,
   output logic [GPIO_WIDTH-1:0] sync,
   output logic [GPIO_WIDTH-1:0] rise
);

   logic [GPIO_WIDTH-1:0] meta_q;
   logic [GPIO_WIDTH-1:0] sync_q;
   logic [GPIO_WIDTH-1:0] prev_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         meta_q <= pins;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync = sync_q;
   assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/mmio_bus_gpio.sv
// Core-to-memory bus bridge with on-bus GPIO; GPIO/unmapped complete in 1 cycle, memory in MEM_LATENCY+2.
// Core holds req_i until the one-cycle ready_o pulse; one transaction in flight at a time.
module mmio_bus_gpio
   import riscv_bus_pkg::*;
#(
   parameter int                    DATA_WIDTH    = 32,
   parameter int                    MEMORY_DEPTH  = 32,
   parameter logic [DATA_WIDTH-1:0] MEM_BASE      = 32'h1001_0000,
   parameter logic [DATA_WIDTH-1:0] GPIO_BASE     = 32'h1002_0000,
   parameter int                    GPIO_WIDTH    = 8,
   parameter int                    GPIO_CHANNELS = 2,
   parameter int                    MEM_LATENCY   = 1
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                req_i,
   input  logic                                we_i,
   input  logic [DATA_WIDTH-1:0]               addr_i,
   input  logic [DATA_WIDTH-1:0]               wdata_i,
   output logic [DATA_WIDTH-1:0]               rdata_o,
   output logic                                ready_o,
   output logic                                err_o,
   output logic [DATA_WIDTH-1:0]               mem_addr_o,
   output logic [DATA_WIDTH-1:0]               mem_wdata_o,
   output logic                                mem_we_o,
   input  logic [DATA_WIDTH-1:0]               mem_rdata_i,
   input  logic [GPIO_CHANNELS*GPIO_WIDTH-1:0] gpio_in_i,
   output logic [GPIO_CHANNELS*GPIO_WIDTH-1:0] gpio_out_o,
   output logic                                irq_o
);

   localparam int CH_W = (GPIO_CHANNELS > 1) ? $clog2(GPIO_CHANNELS) : 1;

   bus_state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic first_q, first_d;
   logic err_q, err_d;
   logic we_q;
   logic latch;
   logic [DATA_WIDTH-1:0] addr_q, wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic [GPIO_CHANNELS-1:0][GPIO_WIDTH-1:0] out_q, out_d;
   logic [GPIO_CHANNELS-1:0][GPIO_WIDTH-1:0] ien_q, ien_d;
   logic [GPIO_CHANNELS-1:0][GPIO_WIDTH-1:0] pend_q, pend_d, pend_clr;
   logic [GPIO_CHANNELS-1:0][GPIO_WIDTH-1:0] sync_v, rise_v;
   logic [GPIO_CHANNELS*GPIO_WIDTH-1:0]      irq_vec;
   logic                                     irq_q;

   region_t          rgn;
   logic [CH_W-1:0]  ch_sel;
   logic [1:0]       reg_sel;
   logic             gpio_acc;
   logic [GPIO_WIDTH-1:0] gpio_rd;

   for (genvar k = 0; k < GPIO_CHANNELS; k++) begin : g_ch
      gpio_sync_edge #(.GPIO_WIDTH(GPIO_WIDTH)) u_sync (
         .clk  (clk),
         .reset(reset),
         .pins (gpio_in_i[k*GPIO_WIDTH +: GPIO_WIDTH]),
         .sync (sync_v[k]),
         .rise (rise_v[k])
      );
   end

   assign rgn = decode_region(64'(addr_i), 64'(MEM_BASE), 64'(4 * MEMORY_DEPTH),
                              64'(GPIO_BASE), 64'(GPIO_STRIDE * GPIO_CHANNELS));
   assign ch_sel   = CH_W'((addr_i - GPIO_BASE) >> 4);
   assign reg_sel  = 2'((addr_i - GPIO_BASE) >> 2);
   assign gpio_acc = (state_q == ST_IDLE) && req_i && (rgn == RGN_GPIO);

   always_comb begin
      gpio_rd = '0;
      case (reg_sel)
         GPIO_REG_OUT:  gpio_rd = out_q[ch_sel];
         GPIO_REG_IN:   gpio_rd = sync_v[ch_sel];
         GPIO_REG_PEND: gpio_rd = pend_q[ch_sel];
         GPIO_REG_IEN:  gpio_rd = ien_q[ch_sel];
         default:       gpio_rd = '0;
      endcase
   end

   // A fresh edge outranks a same-cycle W1C so no event is lost.
   always_comb begin
      out_d    = out_q;
      ien_d    = ien_q;
      pend_clr = '0;
      if (gpio_acc && we_i) begin
         case (reg_sel)
            GPIO_REG_OUT:  out_d[ch_sel]    = wdata_i[GPIO_WIDTH-1:0];
            GPIO_REG_PEND: pend_clr[ch_sel] = wdata_i[GPIO_WIDTH-1:0];
            GPIO_REG_IEN:  ien_d[ch_sel]    = wdata_i[GPIO_WIDTH-1:0];
            default: ;
         endcase
      end
      pend_d  = (pend_q & ~pend_clr) | rise_v;
      irq_vec = pend_d & ien_d;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      first_d = 1'b0;
      err_d   = err_q;
      rdata_d = rdata_q;
      latch   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_i) begin
               err_d   = 1'b0;
               rdata_d = '0;
               case (rgn)
                  RGN_GPIO: begin
                     rdata_d = we_i ? '0 : DATA_WIDTH'(gpio_rd);
                     state_d = ST_RESP;
                  end
                  RGN_MEM: begin
                     latch   = 1'b1;
                     cnt_d   = 4'(MEM_LATENCY);
                     first_d = 1'b1;
                     state_d = ST_MEM_WAIT;
                  end
                  default: begin
                     err_d   = 1'b1;
                     state_d = ST_RESP;
                  end
               endcase
            end
         end
         ST_MEM_WAIT: begin
            if (cnt_q == 4'd0) begin
               rdata_d = we_q ? '0 : mem_rdata_i;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         first_q <= 1'b0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         out_q   <= '0;
         ien_q   <= '0;
         pend_q  <= '0;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         first_q <= first_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         if (latch) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            we_q    <= we_i;
         end
         out_q  <= out_d;
         ien_q  <= ien_d;
         pend_q <= pend_d;
         irq_q  <= |irq_vec;
      end
   end

   assign ready_o     = (state_q == ST_RESP);
   assign rdata_o     = ready_o ? rdata_q : '0;
   assign err_o       = ready_o & err_q;
   assign mem_we_o    = (state_q == ST_MEM_WAIT) & first_q & we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign gpio_out_o  = out_q;
   assign irq_o       = irq_q;

endmodule
